operand_feeder: RTL and testbench

// - Operand source directly upstream of the 3x3 systolic MAC array top. Holds matrix A (N x K) and

---
 rtl/feeder_pkg.sv | 24 ++
 rtl/feeder_lane.sv | 38 +++
 rtl/operand_feeder.sv | 135 +++++++++++++
 tb/tb_operand_feeder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared constants for the operand feeder and the 3x3 systolic MAC array top.
// State encoding, store selectors and default array geometry.
package feeder_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_N = 3;
  localparam int DEF_M = 3;
  localparam int DEF_K = 3;

  localparam logic [1:0] FDR_IDLE   = 2'd0;
  localparam logic [1:0] FDR_STREAM = 2'd1;
  localparam logic [1:0] FDR_DONE   = 2'd2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // index width able to address max(a, b) entries, never narrower than 1
  function automatic int fdr_aw(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/feeder_lane.sv
// One operand lane: pop counter 0..K, element mux and exhausted flag.
// Output is zero whenever the feeder is not streaming or the lane is drained.
module feeder_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int K = 3,
  localparam int CW = $clog2(K + 1),
  localparam int IW = (K > 1) ? $clog2(K) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  active,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] elems [K],
  output logic [DATA_WIDTH-1:0] data,
  output logic                  exhausted
);

  localparam logic [CW-1:0] LAST = CW'(K);

  logic [CW-1:0] cnt;

  assign exhausted = (cnt == LAST);

  // advance on each accepted pop; a new stream restarts from element 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (active && pop && !exhausted) cnt <= cnt + 1'b1;
  end

  // present the current element while the lane still has data
  always_comb begin
    data = '0;
    if (active && !exhausted) data = elems[IW'(cnt)];
  end

endmodule

// File: rtl/operand_feeder.sv
// Operand feeder: holds A (N x K) and B (K x M), streams them per lane.
// Optional FEEDER_OVERRUN_CHECK_EN enables the sticky overrun flag.
module operand_feeder
  import feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N = DEF_N,
  parameter int M = DEF_M,
  parameter int K = DEF_K,
  localparam int RW = fdr_aw(N, K),
  localparam int CLW = fdr_aw(K, M)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [RW-1:0]           wr_row,
  input  logic [CLW-1:0]          wr_col,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    start,
  input  logic [N-1:0]            A_read_en,
  input  logic [M-1:0]            B_read_en,
  output logic [N*DATA_WIDTH-1:0] A_out,
  output logic [M*DATA_WIDTH-1:0] B_out,
  output logic                    busy,
  output logic                    finished,
  output logic                    overrun
);

  logic [1:0] state;
  logic [1:0] state_nx;

  logic [DATA_WIDTH-1:0] a_mem [N][K];
  logic [DATA_WIDTH-1:0] b_mem [K][M];
  logic [DATA_WIDTH-1:0] b_col [M][K];

  logic [N-1:0] a_exh;
  logic [M-1:0] b_exh;
  logic streaming;
  logic clr;
  logic in_range;
  logic wr_ok;
  logic all_done;

  assign streaming = (state == FDR_STREAM);
  assign clr = start && !streaming;
  assign all_done = (&a_exh) && (&b_exh);

  assign in_range = (wr_sel == SEL_A)
    ? (32'(wr_row) < N && 32'(wr_col) < K)
    : (32'(wr_row) < K && 32'(wr_col) < M);
  assign wr_ok = wr_en && !streaming && in_range;

  // host write lands in the selected store on this edge
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel == SEL_A) a_mem[wr_row][wr_col] <= wr_data;
      else b_mem[wr_row][wr_col] <= wr_data;
    end
  end

  for (genvar j = 0; j < M; j++) begin : g_bcol
    for (genvar k = 0; k < K; k++) begin : g_bk
      assign b_col[j][k] = b_mem[k][j];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_a
    feeder_lane #(.DATA_WIDTH(DATA_WIDTH), .K(K)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .active   (streaming),
      .pop      (A_read_en[i]),
      .elems    (a_mem[i]),
      .data     (A_out[i*DATA_WIDTH +: DATA_WIDTH]),
      .exhausted(a_exh[i])
    );
  end

  for (genvar j = 0; j < M; j++) begin : g_b
    feeder_lane #(.DATA_WIDTH(DATA_WIDTH), .K(K)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .active   (streaming),
      .pop      (B_read_en[j]),
      .elems    (b_col[j]),
      .data     (B_out[j*DATA_WIDTH +: DATA_WIDTH]),
      .exhausted(b_exh[j])
    );
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FDR_IDLE;
    else state <= state_nx;
  end

  // next state: DONE once every lane has drained, restart only outside STREAM
  always_comb begin
    state_nx = state;
    case (state)
      FDR_IDLE:   if (start) state_nx = FDR_STREAM;
      FDR_STREAM: if (all_done) state_nx = FDR_DONE;
      FDR_DONE:   if (start) state_nx = FDR_STREAM;
      default:    state_nx = FDR_IDLE;
    endcase
  end

  // status outputs decoded from the registered state
  always_comb begin
    busy = streaming;
    finished = (state == FDR_DONE);
  end

`ifdef FEEDER_OVERRUN_CHECK_EN
  logic ov_q;
  logic bad_pop;

  assign bad_pop = (|(A_read_en & a_exh)) || (|(B_read_en & b_exh));

  // sticky misuse flag, cleared by a fresh stream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ov_q <= 1'b0;
    else if (clr) ov_q <= 1'b0;
    else if (bad_pop || (wr_en && streaming)) ov_q <= 1'b1;
  end

  assign overrun = ov_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_operand_feeder.sv
// Scoreboard bench for operand_feeder: load, stream, skew, misuse, reset, reload.
// Expected lane values are queued at pop time and compared at the falling edge.
module tb_operand_feeder;
  import feeder_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int N = DEF_N;
  localparam int M = DEF_M;
  localparam int K = DEF_K;
`ifdef FEEDER_OVERRUN_CHECK_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic wr_en;
  logic wr_sel;
  logic [1:0] wr_row;
  logic [1:0] wr_col;
  logic [DW-1:0] wr_data;
  logic start;
  logic [N-1:0] A_read_en;
  logic [M-1:0] B_read_en;
  logic [N*DW-1:0] A_out;
  logic [M*DW-1:0] B_out;
  logic busy;
  logic finished;
  logic overrun;

  operand_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .start    (start),
    .A_read_en(A_read_en),
    .B_read_en(B_read_en),
    .A_out    (A_out),
    .B_out    (B_out),
    .busy     (busy),
    .finished (finished),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] ma [N][K];
  logic [DW-1:0] mb [K][M];
  int ca [N];
  int cb [M];
  bit m_ov;
  logic [DW-1:0] expq [$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_ov();
    return OV_EN & m_ov;
  endfunction

  task automatic wr(input logic sel, input int r, input int c,
                    input logic [DW-1:0] d, input bit live);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_row = 2'(r);
    wr_col = 2'(c);
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (live) m_ov = 1'b1;
    else if (sel == SEL_A && r < N && c < K) ma[r][c] = d;
    else if (sel == SEL_B && r < K && c < M) mb[r][c] = d;
  endtask

  task automatic go();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    foreach (ca[i]) ca[i] = 0;
    foreach (cb[j]) cb[j] = 0;
    m_ov = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_fin", finished, 1'b0);
  endtask

  task automatic pop(input logic [N-1:0] ae, input logic [M-1:0] be);
    logic [DW-1:0] e;
    A_read_en = ae;
    B_read_en = be;
    for (int i = 0; i < N; i++)
      if (ae[i]) expq.push_back(ca[i] < K ? ma[i][ca[i]] : '0);
    for (int j = 0; j < M; j++)
      if (be[j]) expq.push_back(cb[j] < K ? mb[cb[j]][j] : '0);
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (ae[i]) begin
        e = expq.pop_front();
        chk($sformatf("a_lane%0d", i), A_out[i*DW +: DW], e);
      end
    for (int j = 0; j < M; j++)
      if (be[j]) begin
        e = expq.pop_front();
        chk($sformatf("b_lane%0d", j), B_out[j*DW +: DW], e);
      end
    chk("pop_busy", busy, 1'b1);
    chk("pop_fin", finished, 1'b0);
    @(posedge clk);
    #1;
    A_read_en = '0;
    B_read_en = '0;
    for (int i = 0; i < N; i++)
      if (ae[i]) begin
        if (ca[i] < K) ca[i]++;
        else m_ov = 1'b1;
      end
    for (int j = 0; j < M; j++)
      if (be[j]) begin
        if (cb[j] < K) cb[j]++;
        else m_ov = 1'b1;
      end
  endtask

  task automatic wait_fin(input string tag);
    int n;
    n = 0;
    while (!finished && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_fin"}, finished, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_aout"}, A_out, '0);
    chk({tag, "_ov"}, overrun, exp_ov());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_sel = SEL_A;
    wr_row = '0;
    wr_col = '0;
    wr_data = '0;
    start = 1'b0;
    A_read_en = '0;
    B_read_en = '0;
    m_ov = 1'b0;
    foreach (ca[i]) ca[i] = 0;
    foreach (cb[j]) cb[j] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fin", finished, 1'b0);
    chk("rst_ov", overrun, 1'b0);
    chk("rst_aout", A_out, '0);
    chk("rst_bout", B_out, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // load A = 1..9 row-major, B = identity, plus dropped out-of-range writes
    for (int r = 0; r < N; r++)
      for (int c = 0; c < K; c++)
        wr(SEL_A, r, c, DW'(r * K + c + 1), 1'b0);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < M; c++)
        wr(SEL_B, r, c, (r == c) ? DW'(1) : DW'(0), 1'b0);
    wr(SEL_A, 3, 0, 32'h77, 1'b0);
    wr(SEL_B, 0, 3, 32'h88, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // full-width pops
    go();
    repeat (3) pop('1, '1);
    @(negedge clk);
    chk("drained_a", A_out, '0);
    chk("drained_b", B_out, '0);
    wait_fin("full");

    // skewed pops
    go();
    pop(3'b001, 3'b001);
    pop(3'b011, 3'b011);
    pop(3'b111, 3'b111);
    pop(3'b110, 3'b110);
    pop(3'b100, 3'b100);
    wait_fin("skew");

    // extra pop on an exhausted lane
    go();
    repeat (3) pop('1, '1);
    pop(3'b001, 3'b000);
    chk("xpop_ov", overrun, exp_ov());
    wait_fin("xpop");

    // write during streaming is dropped
    go();
    chk("restart_ov", overrun, 1'b0);
    wr(SEL_A, 1, 1, 32'hDEAD, 1'b1);
    chk("busywr_ov", overrun, exp_ov());
    repeat (3) pop('1, '1);
    wait_fin("busywr");

    // reset mid-stream, then restream from retained data
    go();
    pop('1, '1);
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_fin", finished, 1'b0);
    chk("mrst_aout", A_out, '0);
    chk("mrst_bout", B_out, '0);
    chk("mrst_ov", overrun, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ov = 1'b0;
    go();
    repeat (3) pop('1, '1);
    wait_fin("mrst");

    // rewrite A[0][0] in DONE together with start
    wr_en = 1'b1;
    wr_sel = SEL_A;
    wr_row = 2'd0;
    wr_col = 2'd0;
    wr_data = 32'd42;
    start = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    start = 1'b0;
    ma[0][0] = 32'd42;
    foreach (ca[i]) ca[i] = 0;
    foreach (cb[j]) cb[j] = 0;
    m_ov = 1'b0;
    chk("rw_fin_drop", finished, 1'b0);
    chk("rw_busy", busy, 1'b1);
    repeat (3) pop('1, '1);
    wait_fin("rw");

    chk("q_empty", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
